// File: rtl/commit_retire_ctrl_pkg.sv
// Shared constants and types for the commit queue. The done-port order is
// the same one alu_ctrl uses.
package commit_retire_ctrl_pkg;
    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = $clog2(NCOMMIT);
    localparam int NALLOC   = 4;
    localparam int NDONE    = 6;
    localparam int NRETIRE  = 4;
    localparam int ACW      = $clog2(NALLOC + 1);
    localparam int RCW      = $clog2(NRETIRE + 1);

    typedef logic [LNCOMMIT-1:0] cidx_t;
    typedef logic [LNCOMMIT:0]   ccount_t;

    typedef enum logic [2:0] {
        DONE_ALU0  = 3'd0,
        DONE_ALU1  = 3'd1,
        DONE_SHIFT = 3'd2,
        DONE_MUL   = 3'd3,
        DONE_LOAD0 = 3'd4,
        DONE_LOAD1 = 3'd5
    } done_port_e;

    // Wraps naturally because NCOMMIT is a power of two.
    function automatic cidx_t idx_add(cidx_t base, int off);
        return cidx_t'(base + cidx_t'(off));
    endfunction
endpackage

// File: rtl/commit_retire_ctrl_if.sv
// Renamer / functional-unit / retire-side signals of the commit queue.
// The master side drives requests; the controller is the slave.
interface commit_retire_ctrl_if;
    import commit_retire_ctrl_pkg::*;

    logic [ACW-1:0]            alloc_count;
    logic                      alloc_ready;
    cidx_t                     alloc_base;
    logic [NDONE-1:0]          done_valid;
    logic [NDONE*LNCOMMIT-1:0] done_addr;
    logic                      kill_valid;
    cidx_t                     kill_addr;
    logic                      retire_stall;
    logic [RCW-1:0]            retire_count;
    logic [NCOMMIT-1:0]        retire_mask;
    cidx_t                     commit_head;
    logic                      commit_empty;

    modport master (
        output alloc_count, done_valid, done_addr, kill_valid, kill_addr, retire_stall,
        input  alloc_ready, alloc_base, retire_count, retire_mask, commit_head, commit_empty
    );

    modport slave (
        input  alloc_count, done_valid, done_addr, kill_valid, kill_addr, retire_stall,
        output alloc_ready, alloc_base, retire_count, retire_mask, commit_head, commit_empty
    );
endinterface

// File: rtl/commit_retire_ctrl_rot.sv
// Rotates a vector right so that bit `shift` lands at bit 0 (head-relative view).
module rot #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] dout
);
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            dout[i] = din[SHW'(SHW'(i) + shift)];
    end
endmodule

// File: rtl/commit_retire_ctrl.sv
// In-order completion, retirement and kill-rewind for the circular commit queue.
// head is also the age-ordering rotation base exported to the scheduler.
module commit_retire_ctrl
    import commit_retire_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    commit_retire_ctrl_if.slave bus
);
    cidx_t              head, tail;
    ccount_t            count;
    logic [NCOMMIT-1:0] valid, done;

    logic [NCOMMIT-1:0] retirable, ready_rot;
    logic [RCW-1:0]     rcount;
    logic [NCOMMIT-1:0] rmask;
    logic               run;
    logic [ACW-1:0]     alloc_acc;
    cidx_t              head_next, tail_next, kill_span;
    ccount_t            count_next;
    logic [NCOMMIT-1:0] valid_next, done_next;

    assign retirable = valid & done;

    rot #(.WIDTH(NCOMMIT), .SHW(LNCOMMIT)) u_rot (
        .din  (retirable),
        .shift(head),
        .dout (ready_rot)
    );

    // Leading-ones count from the head, capped at NRETIRE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rcount = '0;
        run    = 1'b1;
        for (int i = 0; i < NRETIRE; i++) begin
            run = run & ready_rot[i];
            if (run) rcount = rcount + RCW'(1);
        end
        if (bus.retire_stall) rcount = '0;
        rmask = '0;
        for (int i = 0; i < NRETIRE; i++)
            if (i < int'(rcount)) rmask[idx_add(head, i)] = 1'b1;
    end

    assign bus.retire_count = rcount;
    assign bus.retire_mask  = rmask;
    assign bus.commit_head  = head;
    assign bus.alloc_base   = tail;
    assign bus.commit_empty = (count == '0);
    assign bus.alloc_ready  = (count <= ccount_t'(NCOMMIT - NALLOC));

    always_comb begin
        alloc_acc  = (bus.alloc_ready && !bus.kill_valid) ? bus.alloc_count : '0;
        head_next  = cidx_t'(head + cidx_t'(rcount));
        kill_span  = cidx_t'(tail - bus.kill_addr - cidx_t'(1));
        valid_next = valid;
        done_next  = done;

        // Reports to entries that are no longer valid are dropped.
        for (int k = 0; k < NDONE; k++)
            if (bus.done_valid[k] && valid[bus.done_addr[k*LNCOMMIT +: LNCOMMIT]])
                done_next[bus.done_addr[k*LNCOMMIT +: LNCOMMIT]] = 1'b1;

        valid_next = valid_next & ~rmask;
        done_next  = done_next & ~rmask;

        if (bus.kill_valid) begin
            // Entries younger than kill_addr, up to tail-1, are squashed.
            for (int i = 0; i < NCOMMIT; i++)
                if (cidx_t'(cidx_t'(i) - bus.kill_addr - cidx_t'(1)) < kill_span) begin
                    valid_next[i] = 1'b0;
                    done_next[i]  = 1'b0;
                end
            tail_next  = cidx_t'(bus.kill_addr + cidx_t'(1));
            count_next = {1'b0, cidx_t'(bus.kill_addr - head_next + cidx_t'(1))};
        end else begin
            for (int i = 0; i < NALLOC; i++)
                if (i < int'(alloc_acc)) begin
                    valid_next[idx_add(tail, i)] = 1'b1;
                    done_next[idx_add(tail, i)]  = 1'b0;
                end
            tail_next  = cidx_t'(tail + cidx_t'(alloc_acc));
            count_next = ccount_t'(count + ccount_t'(alloc_acc) - ccount_t'(rcount));
        end
    end

    // NOTE: valid/done are flops rather than a RAM and must be reset, since they define occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            valid <= valid_next;
            done  <= done_next;
        end
    end
endmodule
